// File: rtl/perfect_scan_pkg.sv
// rtl/perfect_scan_pkg.sv - shared types and constants for the perfect-number scan sequencer
package perfect_scan_pkg;

  localparam int CAND_W   = 16;
  localparam int HITCNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_NEXT,
    ST_FIN
  } scan_state_e;

  function automatic logic [HITCNT_W-1:0] sat_inc(input logic [HITCNT_W-1:0] v);
    return (v == {HITCNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/scan_hit_fifo.sv
// rtl/scan_hit_fifo.sv - first-word fall-through hit FIFO, extra pointer MSB for full/empty
module scan_hit_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, rd_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_pop, do_push;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= din_i;
        wr_q                <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/perfect_scan_ctrl.sv
// rtl/perfect_scan_ctrl.sv - candidate sweep sequencer for the perfect-number checker
// Optional per-candidate watchdog enabled by SCAN_TIMEOUT_EN.
module perfect_scan_ctrl
  import perfect_scan_pkg::*;
#(
  parameter int W     = CAND_W,
  parameter int DEPTH = 4
`ifdef SCAN_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 65535
`endif
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [W-1:0]        lo_i,
  input  logic [W-1:0]        hi_i,
  output logic [W-1:0]        sw_o,
  output logic                go_o,
  input  logic                over_i,
  input  logic                ans_i,
  input  logic                rd_en_i,
  output logic [W-1:0]        rd_data_o,
  output logic                empty_o,
  output logic [HITCNT_W-1:0] hit_cnt_o,
  output logic                overflow_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  scan_state_e         state_q;
  logic [W-1:0]        cand_q, hi_q, sw_q;
  logic [HITCNT_W-1:0] hit_cnt_q;
  logic                go_q, done_q, busy_q, overflow_q, over_q;
  logic                ov_rise, ov_take, hit, fifo_full;

  assign ov_rise = over_i && !over_q;
  // An over arriving with go still high belongs to the previous candidate.
  assign ov_take = (state_q == ST_WAIT) && ov_rise && !go_q && !abort_i;
  assign hit     = ov_take && ans_i;

  scan_hit_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (hit),
    .din_i  (cand_q),
    .pop_i  (rd_en_i),
    .dout_o (rd_data_o),
    .empty_o(empty_o),
    .full_o (fifo_full)
  );

`ifdef SCAN_TIMEOUT_EN
  logic [31:0] tmo_q;
  logic        err_q;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cand_q     <= '0;
      hi_q       <= '0;
      sw_q       <= '0;
      hit_cnt_q  <= '0;
      go_q       <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      over_q     <= 1'b0;
`ifdef SCAN_TIMEOUT_EN
      tmo_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      over_q <= over_i;
      go_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            cand_q     <= lo_i;
            hi_q       <= hi_i;
            hit_cnt_q  <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef SCAN_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
            state_q    <= (lo_i > hi_i) ? ST_FIN : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (abort_i) begin
            state_q <= ST_FIN;
          end else if (cand_q < W'(2)) begin
            state_q <= ST_NEXT;
          end else begin
            sw_q    <= cand_q;
            go_q    <= 1'b1;
            state_q <= ST_WAIT;
`ifdef SCAN_TIMEOUT_EN
            tmo_q   <= '0;
`endif
          end
        end
        ST_WAIT: begin
          if (abort_i) begin
            state_q <= ST_FIN;
          end else if (ov_take) begin
            if (ans_i) begin
              hit_cnt_q <= sat_inc(hit_cnt_q);
              if (fifo_full && !rd_en_i) overflow_q <= 1'b1;
            end
            state_q <= ST_NEXT;
          end
`ifdef SCAN_TIMEOUT_EN
          else if (tmo_q == 32'(TIMEOUT_CYC - 1)) begin
            err_q   <= 1'b1;
            state_q <= ST_FIN;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        ST_NEXT: begin
          // Compare before incrementing so hi = all-ones terminates without wrapping.
          if (abort_i || cand_q == hi_q) begin
            state_q <= ST_FIN;
          end else begin
            cand_q  <= cand_q + 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sw_o       = sw_q;
  assign go_o       = go_q;
  assign hit_cnt_o  = hit_cnt_q;
  assign overflow_o = overflow_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_perfect_scan_ctrl.sv
// tb/tb_perfect_scan_ctrl.sv - directed self-checking bench for perfect_scan_ctrl
module tb_perfect_scan_ctrl;

  localparam int LAT = 5;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0, abort_i = 1'b0, rd_en_i = 1'b0;
  logic [15:0] lo_i = '0, hi_i = '0;
  logic        over_i = 1'b0, ans_i = 1'b0;
  logic [15:0] sw_o, rd_data_o;
  logic [7:0]  hit_cnt_o;
  logic        go_o, empty_o, overflow_o, busy_o, done_o, err_o;

  int errors = 0;
  int checks = 0;

  perfect_scan_ctrl #(
    .W(16), .DEPTH(4)
`ifdef SCAN_TIMEOUT_EN
    , .TIMEOUT_CYC(10)
`endif
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .lo_i(lo_i), .hi_i(hi_i), .sw_o(sw_o), .go_o(go_o), .over_i(over_i), .ans_i(ans_i),
    .rd_en_i(rd_en_i), .rd_data_o(rd_data_o), .empty_o(empty_o), .hit_cnt_o(hit_cnt_o),
    .overflow_o(overflow_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural checker: over rises LAT cycles after go and stays high 2 cycles.
  int          ans_mode = 0;   // 0 true perfect, 1 force 1, 2 force 0
  bit          man_en = 0, man_over = 0, man_ans = 0;
  bit          pend = 0;
  int          lat = 0, hold = 0, done_cnt = 0;
  logic [15:0] pcand;
  logic [15:0] go_log[$];

  function automatic bit ans_val(input logic [15:0] n);
    if (ans_mode == 1) return 1'b1;
    if (ans_mode == 2) return 1'b0;
    return (n == 6 || n == 28 || n == 496 || n == 8128);
  endfunction

  always @(negedge clk_i) begin
    if (done_o) done_cnt++;
    if (go_o) go_log.push_back(sw_o);
    if (man_en) begin
      over_i = man_over;
      ans_i  = man_ans;
      pend   = 0;
      hold   = 0;
    end else begin
      if (hold > 0) begin
        hold--;
        if (hold == 0) over_i = 1'b0;
      end
      if (go_o) begin
        pend  = 1;
        lat   = LAT;
        pcand = sw_o;
      end else if (pend) begin
        lat--;
        if (lat == 0) begin
          pend   = 0;
          over_i = 1'b1;
          ans_i  = ans_val(pcand);
          hold   = 2;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic do_start(input logic [15:0] lo, input logic [15:0] hi);
    @(posedge clk_i); #1;
    lo_i = lo; hi_i = hi; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_i); #1;
      if (done_o) begin ok = 1; break; end
    end
  endtask

  task automatic wait_go(input logic [15:0] v, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_i); #1;
      if (go_o && sw_o == v) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    cyc(2);
    rst_ni = 1'b1;
    cyc(1);
    checks++; if (sw_o !== 16'h0) begin errors++; $display("FAIL reset_sw got %0h want 0", sw_o); end
    checks++; if (go_o !== 1'b0) begin errors++; $display("FAIL reset_go got %0b want 0", go_o); end
    checks++; if (rd_data_o !== 16'h0) begin errors++; $display("FAIL reset_rd_data got %0h want 0", rd_data_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", empty_o); end
    checks++; if (hit_cnt_o !== 8'd0) begin errors++; $display("FAIL reset_hit_cnt got %0d want 0", hit_cnt_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", err_o); end
  endtask

  task automatic test_scan;
    bit ok;
    int d0, bad;
    ans_mode = 0; man_en = 0;
    go_log.delete();
    d0 = done_cnt;
    do_start(16'd1, 16'd30);
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t1_done_timeout got none want done"); end
    cyc(3);
    checks++; if (go_log.size() != 29) begin errors++; $display("FAIL t1_go_count got %0d want 29", go_log.size()); end
    bad = 0;
    foreach (go_log[i]) if (go_log[i] != 16'(i + 2)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL t1_go_sequence got %0d bad entries want 0", bad); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL t1_done_pulses got %0d want 1", done_cnt - d0); end
    checks++; if (hit_cnt_o !== 8'd2) begin errors++; $display("FAIL t1_hit_cnt got %0d want 2", hit_cnt_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL t1_overflow got %0b want 0", overflow_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL t1_busy got %0b want 0", busy_o); end
    checks++; if (rd_data_o !== 16'd6) begin errors++; $display("FAIL t1_pop0 got %0d want 6", rd_data_o); end
    rd_en_i = 1'b1; cyc(1); rd_en_i = 1'b0;
    checks++; if (rd_data_o !== 16'd28) begin errors++; $display("FAIL t1_pop1 got %0d want 28", rd_data_o); end
    rd_en_i = 1'b1; cyc(1); rd_en_i = 1'b0;
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL t1_empty got %0b want 1", empty_o); end
  endtask

  task automatic test_empty_range;
    go_log.delete();
    do_start(16'd20, 16'd10);
    checks++; if (busy_o !== 1'b1 || done_o !== 1'b0) begin errors++; $display("FAIL t2_cycle1 got busy=%0b done=%0b want busy=1 done=0", busy_o, done_o); end
    cyc(1);
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b1) begin errors++; $display("FAIL t2_cycle2 got busy=%0b done=%0b want busy=0 done=1", busy_o, done_o); end
    cyc(1);
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL t2_done_width got %0b want 0", done_o); end
    cyc(1);
    checks++; if (go_log.size() != 0) begin errors++; $display("FAIL t2_go_count got %0d want 0", go_log.size()); end
    checks++; if (hit_cnt_o !== 8'd0) begin errors++; $display("FAIL t2_hit_cnt got %0d want 0", hit_cnt_o); end
  endtask

  task automatic test_top_of_range;
    bit ok;
    ans_mode = 2;
    go_log.delete();
    do_start(16'hFFFE, 16'hFFFF);
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t3_done_timeout got none want done"); end
    cyc(3);
    checks++; if (go_log.size() != 2) begin errors++; $display("FAIL t3_go_count got %0d want 2", go_log.size()); end
    if (go_log.size() == 2) begin
      checks++; if (go_log[0] !== 16'hFFFE || go_log[1] !== 16'hFFFF) begin errors++; $display("FAIL t3_go_values got %0h,%0h want fffe,ffff", go_log[0], go_log[1]); end
    end
    checks++; if (busy_o !== 1'b0 || hit_cnt_o !== 8'd0) begin errors++; $display("FAIL t3_finish got busy=%0b hits=%0d want busy=0 hits=0", busy_o, hit_cnt_o); end
  endtask

  task automatic test_fifo_full;
    bit ok;
    logic [15:0] got[$];
    ans_mode = 1;
    do_start(16'd2, 16'd9);
    wait_done(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t4a_done_timeout got none want done"); end
    cyc(1);
    checks++; if (hit_cnt_o !== 8'd8) begin errors++; $display("FAIL t4a_hit_cnt got %0d want 8", hit_cnt_o); end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL t4a_overflow got %0b want 1", overflow_o); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_data_o !== 16'(i + 2) || empty_o !== 1'b0) begin errors++; $display("FAIL t4a_pop%0d got %0d empty=%0b want %0d", i, rd_data_o, empty_o, i + 2); end
      rd_en_i = 1'b1; cyc(1); rd_en_i = 1'b0;
    end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL t4a_empty got %0b want 1", empty_o); end

    rd_en_i = 1'b1;
    do_start(16'd2, 16'd9);
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk_i);
      if (!empty_o) got.push_back(rd_data_o);
      if (done_o) begin ok = 1; break; end
    end
    cyc(3);
    rd_en_i = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL t4b_done_timeout got none want done"); end
    checks++; if (got.size() != 8) begin errors++; $display("FAIL t4b_pop_count got %0d want 8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      checks++; if (got[i] !== 16'(i + 2)) begin errors++; $display("FAIL t4b_order%0d got %0d want %0d", i, got[i], i + 2); end
    end
    checks++; if (overflow_o !== 1'b0 || hit_cnt_o !== 8'd8) begin errors++; $display("FAIL t4b_flags got ovf=%0b hits=%0d want ovf=0 hits=8", overflow_o, hit_cnt_o); end
  endtask

  task automatic test_abort;
    bit ok;
    man_en = 1; man_over = 0; man_ans = 0;
    cyc(2);
    do_start(16'd6, 16'd10);
    wait_go(16'd6, 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t5_go6_timeout got none want go"); end
    cyc(1);
    man_over = 1; man_ans = 1; abort_i = 1'b1;
    cyc(1);
    abort_i = 1'b0;
    cyc(1);
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL t5_abort_done got %0b want 1", done_o); end
    man_over = 0;
    cyc(2);
    man_over = 1;
    cyc(3);
    checks++; if (empty_o !== 1'b1 || hit_cnt_o !== 8'd0) begin errors++; $display("FAIL t5_no_push got empty=%0b hits=%0d want empty=1 hits=0", empty_o, hit_cnt_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL t5_late_over got busy=%0b want 0", busy_o); end
    man_over = 0;
    cyc(2);
  endtask

  task automatic test_reset_mid_scan;
    bit ok;
    int d0;
    do_start(16'd6, 16'd10);
    wait_go(16'd6, 50, ok);
    cyc(1);
    man_over = 1; man_ans = 1;
    cyc(2);
    man_over = 0;
    wait_go(16'd7, 50, ok);
    checks++; if (!ok || empty_o !== 1'b0) begin errors++; $display("FAIL t5r_setup got go7=%0b empty=%0b want go7=1 empty=0", ok, empty_o); end
    cyc(1);
    d0 = done_cnt;
    #3 rst_ni = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0 || sw_o !== 16'h0 || empty_o !== 1'b1 || hit_cnt_o !== 8'd0 || rd_data_o !== 16'h0 || go_o !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("FAIL t5r_async_reset got busy=%0b sw=%0h empty=%0b hits=%0d rd=%0h go=%0b done=%0b want 0,0,1,0,0,0,0", busy_o, sw_o, empty_o, hit_cnt_o, rd_data_o, go_o, done_o);
    end
    @(posedge clk_i); #1 rst_ni = 1'b1;
    cyc(6);
    checks++; if (done_cnt != d0 || busy_o !== 1'b0) begin errors++; $display("FAIL t5r_no_done got done_pulses=%0d busy=%0b want 0,0", done_cnt - d0, busy_o); end
    man_en = 0;
  endtask

`ifdef SCAN_TIMEOUT_EN
  task automatic test_timeout;
    bit ok;
    int n;
    man_en = 1; man_over = 0;
    do_start(16'd6, 16'd6);
    wait_go(16'd6, 50, ok);
    n = 0; ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk_i); #1; n++;
      if (done_o) begin ok = 1; break; end
    end
    checks++; if (!ok || n > 12) begin errors++; $display("FAIL t6_timeout_done got ok=%0b cycles=%0d want ok=1 cycles<=12", ok, n); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL t6_err got %0b want 1", err_o); end
    do_start(16'd20, 16'd10);
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL t6_err_clear got %0b want 0", err_o); end
    man_en = 0;
    cyc(3);
  endtask
`endif

  initial begin
    test_reset();
    test_scan();
    test_empty_range();
    test_top_of_range();
    test_fifo_full();
    test_abort();
    test_reset_mid_scan();
`ifdef SCAN_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
